// File: rtl/rx_pkg.sv
// Shared encodings for the PCIe RX-to-OCP sequencer: register load codes, operation types,
// TLP fmt/type constants and the sequencer state enum.
package rx_pkg;

  localparam int unsigned AXI_WIDTH  = 64;
  localparam int unsigned KEEP_WIDTH = AXI_WIDTH / 8;

  typedef enum logic [2:0] {
    OCP_IDLE  = 3'd0,
    OCP_H1    = 3'd1,
    OCP_H2    = 3'd2,
    OCP_DATA3 = 3'd3,
    OCP_DATA4 = 3'd4
  } ocp_reg_ctl_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_UNSUP = 2'd3
  } optype_e;

  localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
  localparam logic [1:0] FMT_4DW_NODATA = 2'b01;
  localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
  localparam logic [1:0] FMT_4DW_DATA   = 2'b11;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;

  typedef enum logic [2:0] {
    StHdr1,
    StHdr2,
    StData,
    StCpl,
    StDrain
  } state_e;

endpackage

// File: rtl/rx_tlp_sequencer_if.sv
// RX beat stream, OCP backpressure and completion-header FIFO handshake bundle.
// master: the upstream/environment side; slave: the sequencer.
interface rx_tlp_sequencer_if #(
  parameter int unsigned AXI_WIDTH  = 64,
  parameter int unsigned KEEP_WIDTH = AXI_WIDTH / 8
);
  logic                  rx_valid;
  logic [AXI_WIDTH-1:0]  rx_data;
  logic [KEEP_WIDTH-1:0] rx_keep;
  logic                  rx_last;
  logic                  rx_ready;
  logic                  tx_header_fifo_ready;
  logic                  tx_header_fifo_valid;
  logic                  ocp_ready;
  logic [2:0]            ocp_reg_ctl;
  logic [1:0]            optype;
  logic                  tlp_error;

  modport master (
    output rx_valid, rx_data, rx_keep, rx_last, tx_header_fifo_ready, ocp_ready,
    input  rx_ready, tx_header_fifo_valid, ocp_reg_ctl, optype, tlp_error
  );

  modport slave (
    input  rx_valid, rx_data, rx_keep, rx_last, tx_header_fifo_ready, ocp_ready,
    output rx_ready, tx_header_fifo_valid, ocp_reg_ctl, optype, tlp_error
  );
endinterface

// File: rtl/rx_tlp_decode.sv
// Combinational decode of TLP header DW0 into operation type, 4DW-header flag and
// an 11-bit payload length (a length field of 0 encodes 1024 DWs).
module rx_tlp_decode import rx_pkg::*; (
  input  logic [31:0] i_dw0,
  output optype_e     o_optype,
  output logic        o_is_4dw,
  output logic [10:0] o_len
);
  logic [1:0] w_fmt;
  logic [4:0] w_type;
  logic [9:0] w_len;
  logic       w_unused_bits;

  assign w_fmt         = i_dw0[30:29];
  assign w_type        = i_dw0[28:24];
  assign w_len         = i_dw0[9:0];
  assign w_unused_bits = ^{i_dw0[31], i_dw0[23:10]};

  always_comb begin
    o_optype = OP_UNSUP;
    if (w_type == TYPE_MEM) begin
      unique case (w_fmt)
        FMT_3DW_NODATA, FMT_4DW_NODATA: o_optype = OP_READ;
        FMT_3DW_DATA,   FMT_4DW_DATA:   o_optype = OP_WRITE;
        default:                        o_optype = OP_UNSUP;
      endcase
    end
  end

  assign o_is_4dw = (w_fmt == FMT_4DW_NODATA) || (w_fmt == FMT_4DW_DATA);
  assign o_len    = (w_len == 10'd0) ? 11'd1024 : {1'b0, w_len};

endmodule

// File: rtl/rx_tlp_sequencer.sv
// Sequences 64-bit RX TLP beats into the OCP header/data registers, counts payload DWs
// against rx_last, hands read headers to the completion FIFO and drains unsupported TLPs.
module rx_tlp_sequencer import rx_pkg::*; #(
  parameter int unsigned AXI_WIDTH = 64
) (
  input logic                rx_clk,
  input logic                rx_reset,
  rx_tlp_sequencer_if.slave  bus
);
  state_e       r_state;
  optype_e      r_optype;
  logic         r_is_4dw;
  logic [10:0]  r_len;
  logic [10:0]  r_remaining;
  logic         r_tlp_error;

  logic         w_xfer;
  logic         w_rx_ready;
  ocp_reg_ctl_e w_ocp_reg_ctl;
  optype_e      w_dec_optype;
  logic         w_dec_is_4dw;
  logic [10:0]  w_dec_len;
  logic [10:0]  w_rem_3dw;
  logic         w_exp_last;
  logic [10:0]  w_rem_next;
  logic         w_unused_bits;

  rx_tlp_decode u_decode (
    .i_dw0    (bus.rx_data[31:0]),
    .o_optype (w_dec_optype),
    .o_is_4dw (w_dec_is_4dw),
    .o_len    (w_dec_len)
  );

  assign w_unused_bits = ^{bus.rx_keep, bus.rx_data[AXI_WIDTH-1:32]};
  assign w_xfer        = bus.rx_valid && w_rx_ready;
  // The HDR2 beat of a 3DW write already carries the first payload DW.
  assign w_rem_3dw     = r_len - 11'd1;
  assign w_exp_last    = (r_remaining <= 11'd2);
  assign w_rem_next    = w_exp_last ? 11'd0 : (r_remaining - 11'd2);

  always_comb begin
    w_rx_ready = 1'b0;
    if (!rx_reset) begin
      unique case (r_state)
        StHdr1:         w_rx_ready = 1'b1;
        StHdr2, StData: w_rx_ready = bus.ocp_ready;
        StCpl:          w_rx_ready = 1'b0;
        StDrain:        w_rx_ready = 1'b1;
        default:        w_rx_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_ocp_reg_ctl = OCP_IDLE;
    if (w_xfer) begin
      unique case (r_state)
        StHdr1:  w_ocp_reg_ctl = OCP_H1;
        StHdr2:  w_ocp_reg_ctl = OCP_H2;
        StData:  w_ocp_reg_ctl = r_is_4dw ? OCP_DATA4 : OCP_DATA3;
        default: w_ocp_reg_ctl = OCP_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      r_state     <= StHdr1;
      r_optype    <= OP_NONE;
      r_is_4dw    <= 1'b0;
      r_len       <= 11'd0;
      r_remaining <= 11'd0;
      r_tlp_error <= 1'b0;
    end else begin
      r_tlp_error <= 1'b0;
      unique case (r_state)
        StHdr1: begin
          if (w_xfer) begin
            r_optype <= w_dec_optype;
            r_is_4dw <= w_dec_is_4dw;
            r_len    <= w_dec_len;
            if (bus.rx_last) begin
              r_tlp_error <= 1'b1;
            end else if (w_dec_optype == OP_UNSUP) begin
              r_state <= StDrain;
            end else begin
              r_state <= StHdr2;
            end
          end
        end
        StHdr2: begin
          if (w_xfer) begin
            if (r_optype == OP_READ) begin
              if (bus.rx_last) begin
                r_state <= StCpl;
              end else begin
                r_state     <= StDrain;
                r_tlp_error <= 1'b1;
              end
            end else if (r_is_4dw) begin
              r_remaining <= r_len;
              if (bus.rx_last) begin
                r_state     <= StHdr1;
                r_tlp_error <= 1'b1;
              end else begin
                r_state <= StData;
              end
            end else begin
              r_remaining <= w_rem_3dw;
              if (w_rem_3dw == 11'd0) begin
                r_state     <= bus.rx_last ? StHdr1 : StDrain;
                r_tlp_error <= !bus.rx_last;
              end else begin
                r_state     <= bus.rx_last ? StHdr1 : StData;
                r_tlp_error <= bus.rx_last;
              end
            end
          end
        end
        StData: begin
          if (w_xfer) begin
            r_remaining <= w_rem_next;
            if (w_exp_last) begin
              r_state     <= bus.rx_last ? StHdr1 : StDrain;
              r_tlp_error <= !bus.rx_last;
            end else if (bus.rx_last) begin
              r_state     <= StHdr1;
              r_tlp_error <= 1'b1;
            end
          end
        end
        StCpl: begin
          if (bus.tx_header_fifo_ready) begin
            r_state <= StHdr1;
          end
        end
        StDrain: begin
          if (w_xfer && bus.rx_last) begin
            r_state <= StHdr1;
          end
        end
        default: r_state <= StHdr1;
      endcase
    end
  end

  assign bus.rx_ready             = w_rx_ready;
  assign bus.ocp_reg_ctl          = w_ocp_reg_ctl;
  assign bus.tx_header_fifo_valid = (r_state == StCpl);
  assign bus.optype               = r_optype;
  assign bus.tlp_error            = r_tlp_error;

endmodule

// File: tb/tb_rx_tlp_sequencer.sv
// Self-checking bench: TLP-level reference model (expected per-beat load codes, error and
// completion events derived from header fields and beat counts) plus directed literal checks.
module tb_rx_tlp_sequencer;
  import rx_pkg::*;

  typedef struct {
    int code;
    bit needs_ocp;
    bit err;
    bit cpl;
    bit hdr;
    int optype;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_tlp_sequencer_if #(.AXI_WIDTH(64), .KEEP_WIDTH(8)) bus ();

  rx_tlp_sequencer #(.AXI_WIDTH(64)) dut (
    .rx_clk   (clk),
    .rx_reset (rst),
    .bus      (bus)
  );

  int    checks = 0;
  int    failures = 0;
  beat_t q[$];
  int    acc_codes[$];
  int    fifo_hi_cnt = 0;
  int    err_cnt = 0;
  bit    rand_bp = 1'b0;
  logic  d_ocp = 1'b1;
  logic  d_fifo = 1'b1;
  logic  r_ocp = 1'b1;
  logic  r_fifo = 1'b1;

  assign bus.ocp_ready            = rand_bp ? r_ocp : d_ocp;
  assign bus.tx_header_fifo_ready = rand_bp ? r_fifo : d_fifo;

  always @(posedge clk) begin
    #1;
    r_ocp  = ($urandom_range(0, 3) != 0);
    r_fifo = ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat-by-beat behaviour of one TLP of nb beats, from its header fields.
  task automatic build(input logic [31:0] dw0, input int nb);
    int    fmt, typ, len, op, exp_nb, dcode;
    beat_t b;
    fmt = int'(dw0[30:29]);
    typ = int'(dw0[28:24]);
    len = (dw0[9:0] == 10'd0) ? 1024 : int'(dw0[9:0]);
    op  = (typ != 0) ? 3 : ((fmt >= 2) ? 2 : 1);
    b = '{code: 1, needs_ocp: 1'b0, err: (nb == 1), cpl: 1'b0, hdr: 1'b1, optype: op};
    q.push_back(b);
    if (nb == 1) return;
    if (op == 3) begin
      for (int i = 2; i <= nb; i++) q.push_back('{0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
      return;
    end
    if (op == 1) begin
      q.push_back('{2, 1'b1, (nb != 2), (nb == 2), 1'b0, 0});
      for (int i = 3; i <= nb; i++) q.push_back('{0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
      return;
    end
    dcode  = (fmt == 3) ? 4 : 3;
    exp_nb = (fmt == 3) ? 2 + (len + 1) / 2 : 2 + len / 2;
    for (int i = 2; i <= nb; i++) begin
      if (i > exp_nb) begin
        q.push_back('{0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
      end else begin
        b = '{code: (i == 2) ? 2 : dcode, needs_ocp: 1'b1,
              err: ((i == nb) && (nb < exp_nb)) || ((i == exp_nb) && (nb > exp_nb)),
              cpl: 1'b0, hdr: 1'b0, optype: 0};
        q.push_back(b);
      end
    end
  endtask

  task automatic send(input logic [31:0] dw0, input int nb, input bit gaps, input int stall_at);
    bit acc;
    int n;
    build(dw0, nb);
    for (int i = 1; i <= nb; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.rx_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = (i == 1) ? {$urandom(), dw0} : {$urandom(), $urandom()};
      bus.rx_last  = (i == nb);
      bus.rx_keep  = ((i == nb) && ($urandom_range(0, 1) == 1)) ? 8'h0F : 8'hFF;
      if (i == stall_at) begin
        d_ocp = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_rx_ready", int'(bus.rx_ready), 0);
          chk("bp_ocp_reg_ctl", int'(bus.ocp_reg_ctl), 0);
          @(posedge clk);
          #1;
        end
        d_ocp = 1'b1;
      end
      acc = 1'b0;
      n   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = bus.rx_ready;
        if (acc) acc_codes.push_back(int'(bus.ocp_reg_ctl));
        @(posedge clk);
        #1;
        n++;
        if (!acc && n > 2000) begin
          failures++;
          $display("FAIL beat_timeout: actual=not_accepted required=accepted at %0t", $time);
          $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
          $fatal(1, "beat never accepted");
        end
      end
    end
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    bit    cpl_pend = 1'b0;
    bit    err_next = 1'b0;
    int    exp_op = 0;
    int    exp_rdy;
    beat_t b;
    @(posedge clk);
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (bus.tx_header_fifo_valid) fifo_hi_cnt++;
      if (bus.tlp_error) err_cnt++;
      chk("m_fifo_valid", int'(bus.tx_header_fifo_valid), int'(cpl_pend));
      chk("m_tlp_error", int'(bus.tlp_error), int'(err_next));
      chk("m_optype", int'(bus.optype), exp_op);
      if (rst) begin
        chk("m_rst_ready", int'(bus.rx_ready), 0);
        chk("m_rst_ctl", int'(bus.ocp_reg_ctl), 0);
        cpl_pend = 1'b0;
        err_next = 1'b0;
        exp_op   = 0;
        continue;
      end
      exp_rdy = cpl_pend ? 0 : ((q.size() > 0 && q[0].needs_ocp) ? int'(bus.ocp_ready) : 1);
      chk("m_rx_ready", int'(bus.rx_ready), exp_rdy);
      err_next = 1'b0;
      if (cpl_pend && bus.tx_header_fifo_ready) cpl_pend = 1'b0;
      if (bus.rx_valid && bus.rx_ready) begin
        chk("m_beat_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          b = q.pop_front();
          chk("m_ocp_reg_ctl", int'(bus.ocp_reg_ctl), b.code);
          err_next = b.err;
          if (b.cpl) cpl_pend = 1'b1;
          if (b.hdr) exp_op = b.optype;
        end
      end else begin
        chk("m_ocp_reg_ctl_idle", int'(bus.ocp_reg_ctl), 0);
      end
    end
  end

  initial begin
    int          base, f0, e0, k, len10, fmt, typ, nb, r;
    logic [31:0] dw0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.rx_keep  = 8'hFF;
    bus.rx_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_ready", int'(bus.rx_ready), 0);
    chk("reset_optype", int'(bus.optype), 0);
    chk("reset_fifo_valid", int'(bus.tx_header_fifo_valid), 0);
    chk("reset_tlp_error", int'(bus.tlp_error), 0);
    chk("reset_ctl", int'(bus.ocp_reg_ctl), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 3DW MRd len 1
    base = acc_codes.size();
    f0   = fifo_hi_cnt;
    send(32'h0000_0001, 2, 1'b0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_h1", acc_codes[base], 1);
    chk("t1_h2", acc_codes[base + 1], 2);
    chk("t1_optype", int'(bus.optype), 1);
    chk("t1_fifo_cycles", fifo_hi_cnt - f0, 1);
    chk("t1_rx_ready", int'(bus.rx_ready), 1);
    @(posedge clk);
    #1;

    // 3DW MWr len 4
    base = acc_codes.size();
    e0   = err_cnt;
    send(32'h4000_0004, 4, 1'b0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t2_c0", acc_codes[base], 1);
    chk("t2_c1", acc_codes[base + 1], 2);
    chk("t2_c2", acc_codes[base + 2], 3);
    chk("t2_c3", acc_codes[base + 3], 3);
    chk("t2_optype", int'(bus.optype), 2);
    chk("t2_no_error", err_cnt - e0, 0);
    chk("t2_rx_ready", int'(bus.rx_ready), 1);
    @(posedge clk);
    #1;

    // 4DW MWr len 2 with OCP backpressure on the data beat
    base = acc_codes.size();
    send(32'h6000_0002, 3, 1'b0, 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t3_beats", acc_codes.size() - base, 3);
    chk("t3_data4", acc_codes[base + 2], 4);
    chk("t3_rx_ready", int'(bus.rx_ready), 1);
    @(posedge clk);
    #1;

    // Unsupported type 00100, 5 beats
    base = acc_codes.size();
    e0   = err_cnt;
    send(32'h0400_0003, 5, 1'b0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t4_h1", acc_codes[base], 1);
    chk("t4_drain_ctl", acc_codes[base + 1] + acc_codes[base + 4], 0);
    chk("t4_optype", int'(bus.optype), 3);
    chk("t4_no_error", err_cnt - e0, 0);
    chk("t4_rx_ready", int'(bus.rx_ready), 1);
    @(posedge clk);
    #1;

    // MWr len 6 with rx_last on the second data beat
    e0 = err_cnt;
    send(32'h4000_0006, 4, 1'b0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_error_pulses", err_cnt - e0, 1);
    chk("t5_rx_ready", int'(bus.rx_ready), 1);
    @(posedge clk);
    #1;

    // Randomized traffic with random OCP / FIFO backpressure
    rand_bp = 1'b1;
    for (int t = 0; t < 150; t++) begin
      k     = $urandom_range(0, 9);
      len10 = (t == 75) ? 0 : $urandom_range(1, 9);
      fmt   = $urandom_range(0, 3);
      typ   = (k < 8) ? 0 : $urandom_range(1, 31);
      dw0   = $urandom();
      dw0[30:29] = fmt[1:0];
      dw0[28:24] = typ[4:0];
      dw0[9:0]   = len10[9:0];
      if (len10 == 0) len10 = 1024;
      if (typ != 0) nb = $urandom_range(1, 5);
      else if (fmt < 2) nb = 2;
      else if (fmt == 2) nb = 2 + len10 / 2;
      else nb = 2 + (len10 + 1) / 2;
      r = $urandom_range(0, 7);
      if (r == 0) nb = nb + 1;
      if (r == 1 && nb > 1) nb = nb - 1;
      send(dw0, nb, 1'b1, 0);
    end
    rand_bp = 1'b0;
    d_ocp   = 1'b1;
    d_fifo  = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Completion FIFO stall, then reset in the third stalled cycle
    d_fifo = 1'b0;
    send(32'h0000_0001, 2, 1'b0, 0);
    repeat (2) begin
      @(negedge clk);
      chk("t6_valid_held", int'(bus.tx_header_fifo_valid), 1);
      chk("t6_rx_ready_low", int'(bus.rx_ready), 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t6_valid_in_reset", int'(bus.tx_header_fifo_valid), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_dropped", int'(bus.tx_header_fifo_valid), 0);
    chk("t6_optype_reset", int'(bus.optype), 0);
    @(posedge clk);
    #1;
    base = acc_codes.size();
    send(32'h4000_0001, 2, 1'b0, 0);
    chk("t6_first_is_h1", acc_codes[base], 1);
    d_fifo = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("model_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_tlp_sequencer.md
# rx_tlp_sequencer

- Receive-side controller that sequences the 64-bit PCIe AXI-Stream RX datapath into the OCP translation registers.
- Decodes the TLP header on the first beat and drives the `ocp_reg_ctl` load codes (IDLE/H1/H2/DATA3/DATA4) for the header and data shift registers.
- Throttles `rx_ready` against OCP and completion-header-FIFO backpressure.
- Counts payload DWs to check `rx_last`, and drains TLPs it does not support.

## Interface
- `AXI_WIDTH`, 64, RX beat width; only 64 is supported.
- `KEEP_WIDTH`, 8, byte-enable width (`AXI_WIDTH`/8).
- `rx_clk`  in  1  sole clock.
- `rx_reset`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  AXI beat valid.
- `rx_data`  in  AXI_WIDTH  AXI beat; DW0 in [31:0], DW1 in [63:32].
- `rx_keep`  in  KEEP_WIDTH  byte enables; 8'h0F on a last beat carrying one DW, otherwise 8'hFF.
- `rx_last`  in  1  final beat of the TLP.
- `rx_ready`  out  1  beat accept.
- `tx_header_fifo_ready`  in  1  completion header FIFO can accept.
- `tx_header_fifo_valid`  out  1  push the captured read header into the FIFO.
- `ocp_ready`  in  1  OCP side can take a command or data word this cycle.
- `ocp_reg_ctl`  out  3  register load code: 0 IDLE, 1 H1, 2 H2, 3 DATA3, 4 DATA4.
- `optype`  out  2  0 NONE, 1 READ, 2 WRITE, 3 UNSUP; registered.
- `tlp_error`  out  1  one-cycle pulse on a length/`rx_last` mismatch.

## Operation
- A beat transfers when `rx_valid && rx_ready` (abbreviated `xfer`).
- States: HDR1 (post-reset), HDR2, DATA, CPL, DRAIN.
- `ocp_reg_ctl` is IDLE in every cycle without an `xfer`. During an `xfer` it is:
  - HDR1 → H1;
  - HDR2 → H2;
  - DATA with a 3DW header → DATA3;
  - DATA with a 4DW header → DATA4;
  - DRAIN → IDLE.
- Decode happens on the HDR1 `xfer`, using fmt = `rx_data[30:29]`, type = `rx_data[28:24]`, len = `rx_data[9:0]` (0 means 1024). The result is registered as `optype`, a 4DW flag and `len`.
  - MRd (type 00000): fmt 00 is a 3DW read, fmt 01 is a 4DW read; `optype` = READ.
  - MWr (type 00000): fmt 10 is a 3DW write, fmt 11 is a 4DW write; `optype` = WRITE.
  - Anything else: `optype` = UNSUP.
- Transitions from HDR1 on `xfer`:
  - `rx_last` asserted → stay in HDR1 and pulse `tlp_error`; 1-beat TLPs are malformed.
  - UNSUP → DRAIN.
  - Otherwise → HDR2.
- Transitions from HDR2 on `xfer`:
  - READ: `rx_last` asserted → CPL. `rx_last` low → DRAIN with a `tlp_error` pulse.
  - WRITE, 3DW: the beat carries data DW0 in [63:32]; `remaining` = len−1.
    - `remaining` = 0 with `rx_last` → HDR1.
    - `remaining` = 0 without `rx_last` → DRAIN plus error.
    - `remaining` > 0 with `rx_last` → HDR1 plus error.
    - Otherwise → DATA.
  - WRITE, 4DW: `remaining` = len.
    - `rx_last` on this beat → HDR1 plus error.
    - Otherwise → DATA.
- DATA, on each `xfer`:
  - `remaining` decrements by min(2, `remaining`).
  - Expected last beat: `remaining` ≤ 2 before the beat.
  - Expected last and `rx_last` → HDR1.
  - Expected last without `rx_last` → DRAIN plus error.
  - `rx_last` early → HDR1 plus error.
- CPL: assert `tx_header_fifo_valid` until `tx_header_fifo_ready`, then return to HDR1.
- DRAIN: accept and discard beats until the `xfer` carrying `rx_last`, then return to HDR1.
- `remaining` is an 11-bit counter and never underflows.
- `optype` holds its value until the next HDR1 `xfer`.

## Timing
- `rx_ready` per state, forced 0 while `rx_reset` is high:
  - HDR1: 1.
  - HDR2: `ocp_ready`.
  - DATA: `ocp_ready`.
  - CPL: 0.
  - DRAIN: 1.
- `ocp_reg_ctl` and `rx_ready` are combinational from state, `ocp_ready` and `rx_valid`, in the same cycle as the beat. The engine loads on the rising edge that ends the `xfer` cycle, so capture latency is 0 cycles.
- `tx_header_fifo_valid` rises in the cycle after the last HDR2 `xfer` and stays high while `tx_header_fifo_ready` is low.
- `tlp_error` is registered: it asserts in the cycle after the offending `xfer`.
- Reset values:
  - state HDR1, `optype` NONE, `remaining` 0, 4DW flag 0;
  - `rx_ready` 0, `ocp_reg_ctl` IDLE, `tx_header_fifo_valid` 0, `tlp_error` 0.
- Reset mid-TLP: the TLP is abandoned. The first `xfer` after reset is treated as a header.
- `rx_valid` low in any state: hold state; `ocp_reg_ctl` is IDLE.

## Structure
- Package `rx_pkg`:
  - `ocp_reg_ctl` encodings;
  - `optype` encodings;
  - fmt/type constants (FMT_3DW_NODATA, FMT_4DW_NODATA, FMT_3DW_DATA, FMT_4DW_DATA, TYPE_MEM);
  - the state enum.
- One natural sub-module, `rx_tlp_decode`: purely combinational decode of DW0 to {optype, 4DW flag, len11}. The FSM, counter and handshakes stay in `rx_tlp_sequencer`.

## Test plan
- **3DW MRd, len 1.** Beats DW0 = 0x00000001, then address beat with `rx_last`; FIFO ready.
  - Expect `ocp_reg_ctl` H1, then H2, and `optype` = READ.
  - Expect `tx_header_fifo_valid` high for 1 cycle, then `rx_ready` = 1.
- **3DW MWr, len 4.** DW0 = 0x40000004 followed by 3 beats, `rx_last` on the 3rd (keep 8'h0F).
  - Expect `ocp_reg_ctl` H1, H2, DATA3, DATA3, then back in HDR1; no error.
- **4DW MWr, len 2, with backpressure.** `ocp_ready` low for 3 cycles during DATA.
  - Expect `rx_ready` = 0 and `ocp_reg_ctl` IDLE for those cycles.
  - Expect exactly one DATA4 `xfer`, then HDR1.
- **Unsupported type.** DW0 type 00100, 5 beats.
  - Expect `optype` = UNSUP, `ocp_reg_ctl` IDLE after H1, all beats accepted, return to HDR1; no error.
- **Length mismatch.** MWr len 6 with `rx_last` on the second DATA beat.
  - Expect a `tlp_error` pulse one cycle later and state HDR1.
- **Completion FIFO stall and reset.** MRd with `tx_header_fifo_ready` low for 4 cycles.
  - Expect valid held and `rx_ready` = 0.
  - Assert `rx_reset` in the 3rd cycle: valid drops next cycle; the next beat decodes as H1.
